// File: rtl/axi_wr_if.sv
// AXI4 write channels (AW, W, B) as used by a single-beat write master.
interface axi_wr_if #(
  parameter int unsigned DATA_WIDTH = 64
);
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  logic [31:0]           awaddr;
  logic [7:0]            awlen;
  logic [2:0]            awsize;
  logic [1:0]            awburst;
  logic                  awvalid;
  logic                  awready;
  logic [DATA_WIDTH-1:0] wdata;
  logic [STRB_WIDTH-1:0] wstrb;
  logic                  wlast;
  logic                  wvalid;
  logic                  wready;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;

  modport master (
    output awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bresp, bvalid,
    output bready
  );

  modport slave (
    input  awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bresp, bvalid,
    input  bready
  );
endinterface

// File: rtl/axi_wr_arbiter.sv
// Two-requester round-robin arbiter issuing single-beat AXI4 writes,
// one transaction outstanding at a time.
module axi_wr_arbiter #(
  parameter int unsigned AXI_DATA_WIDTH = 64
) (
  input  logic                      axi_clk,
  input  logic                      rst,
  input  logic                      req0_valid,
  input  logic [31:0]               req0_addr,
  input  logic [AXI_DATA_WIDTH-1:0] req0_data,
  output logic                      req0_ready,
  output logic                      req0_done,
  output logic [1:0]                req0_resp,
  input  logic                      req1_valid,
  input  logic [31:0]               req1_addr,
  input  logic [AXI_DATA_WIDTH-1:0] req1_data,
  output logic                      req1_ready,
  output logic                      req1_done,
  output logic [1:0]                req1_resp,
  axi_wr_if.master                  axi,
  output logic [15:0]               err_count
);
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned STRB_W = AXI_DATA_WIDTH / 8;
  localparam int unsigned ERR_W  = 16;
  localparam logic [2:0]  AW_SIZE = (AXI_DATA_WIDTH == 128) ? 3'b100 : 3'b011;
  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  if (!(AXI_DATA_WIDTH == 64 || AXI_DATA_WIDTH == 128)) begin : g_bad_width
    $fatal(1, "axi_wr_arbiter: AXI_DATA_WIDTH must be 64 or 128");
  end

  typedef enum logic [1:0] {IDLE, AW, W, B} state_t;

  state_t                    state, state_nx;
  logic                      accept;
  logic                      sel;
  logic                      b_hs;
  logic                      last_q;
  logic                      gnt_q;
  logic [ADDR_W-1:0]         addr_q;
  logic [AXI_DATA_WIDTH-1:0] data_q;
  logic [STRB_W-1:0]         wstrb_q;
  logic [2:0]                awsize_q;
  logic [1:0]                awburst_q;
  logic                      awvalid_q, wvalid_q, wlast_q, bready_q;
  logic                      done0_q, done1_q;
  logic [1:0]                resp0_q, resp1_q;
  logic [ERR_W-1:0]          err_q;

  // Requester 1 wins when alone, or when both are pending and 0 went last.
  assign sel  = req1_valid & (~req0_valid | ~last_q);
  assign b_hs = (state == B) & axi.bvalid;

  always_ff @(posedge axi_clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    case (state)
      IDLE: if (req0_valid | req1_valid) begin
              accept   = 1'b1;
              state_nx = AW;
            end
      AW:   if (axi.awready) state_nx = W;
      W:    if (axi.wready)  state_nx = B;
      B:    if (axi.bvalid)  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Readies are gated by rst so they fall immediately on reset.
  assign req0_ready = ~rst & accept & ~sel;
  assign req1_ready = ~rst & accept & sel;

  always_ff @(posedge axi_clk or posedge rst) begin
    if (rst) begin
      last_q    <= 1'b1;
      gnt_q     <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      wstrb_q   <= '0;
      awsize_q  <= '0;
      awburst_q <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      wlast_q   <= 1'b0;
      bready_q  <= 1'b0;
      done0_q   <= 1'b0;
      done1_q   <= 1'b0;
      resp0_q   <= '0;
      resp1_q   <= '0;
      err_q     <= '0;
    end else begin
      awvalid_q <= (state_nx == AW);
      wvalid_q  <= (state_nx == W);
      wlast_q   <= (state_nx == W);
      bready_q  <= (state_nx == B);
      done0_q   <= b_hs & ~gnt_q;
      done1_q   <= b_hs & gnt_q;
      if (accept) begin
        gnt_q     <= sel;
        last_q    <= sel;
        addr_q    <= sel ? req1_addr : req0_addr;
        data_q    <= sel ? req1_data : req0_data;
        wstrb_q   <= '1;
        awsize_q  <= AW_SIZE;
        awburst_q <= 2'b01;
      end
      if (b_hs) begin
        if (gnt_q) resp1_q <= axi.bresp;
        else       resp0_q <= axi.bresp;
        if (axi.bresp != 2'b00 && err_q != ERR_MAX) err_q <= err_q + ERR_W'(1);
      end
    end
  end

  assign axi.awaddr  = addr_q;
  assign axi.awlen   = 8'd0;
  assign axi.awsize  = awsize_q;
  assign axi.awburst = awburst_q;
  assign axi.awvalid = awvalid_q;
  assign axi.wdata   = data_q;
  assign axi.wstrb   = wstrb_q;
  assign axi.wlast   = wlast_q;
  assign axi.wvalid  = wvalid_q;
  assign axi.bready  = bready_q;

  assign req0_done = done0_q;
  assign req1_done = done1_q;
  assign req0_resp = resp0_q;
  assign req1_resp = resp1_q;
  assign err_count = err_q;
endmodule
